// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the data memory access controller.
package mips_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DONE
    } dmem_state_t;

    typedef enum logic {
        OWN_MS,
        OWN_LD
    } dmem_owner_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a conflict the side not granted last time wins.
module rr_arb2
    import mips_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_ms,
    input  logic req_ld,
    input  logic en,
    output logic gnt_ms,
    output logic gnt_ld
);

    dmem_owner_t last;

    always_comb begin
        gnt_ms = req_ms && (!req_ld || (last == OWN_LD));
        gnt_ld = req_ld && (!req_ms || (last == OWN_MS));
    end

    // Reset value OWN_LD lets the MEM stage win the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= OWN_LD;
        end else if (en && (gnt_ms || gnt_ld)) begin
            last <= gnt_ld ? OWN_LD : OWN_MS;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data memory sequencer: arbitrates MEM-stage lw/sw and the loader port onto a
// fixed-latency memory, and stalls the pipeline while a MEM-stage access is pending.
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        ms_opcode,
    input  logic [ADDR_W-1:0] ms_addr,
    input  logic [DATA_W-1:0] ms_wdata,
    output logic [DATA_W-1:0] ms_rdata,
    output logic              ms_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              dm_read,
    output logic              dm_write,
    output logic [ADDR_W-1:0] dm_raddr,
    output logic [ADDR_W-1:0] dm_waddr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    dmem_state_t       state;
    dmem_owner_t       own;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] raddr_q;

    logic ms_req;
    logic ms_is_sw;
    logic arb_en;
    logic gnt_ms;
    logic gnt_ld;
    logic rd_gnt;

    assign ms_req   = is_mem_op(ms_opcode);
    assign ms_is_sw = (ms_opcode == OP_SW);
    assign arb_en   = !reset && (state == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_ms (arb_en && ms_req),
        .req_ld (arb_en && ld_req),
        .en     (arb_en),
        .gnt_ms (gnt_ms),
        .gnt_ld (gnt_ld)
    );

    assign rd_gnt = (gnt_ms && !ms_is_sw) || (gnt_ld && !ld_we);

    // Grant-cycle strobes come straight from the winner's inputs so a store
    // completes in the cycle it is presented.
    always_comb begin
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_raddr  = '0;
        dm_waddr  = '0;
        dm_wdata  = '0;
        ld_gnt    = 1'b0;
        ld_rvalid = 1'b0;
        ms_stall  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (gnt_ms) begin
                        if (ms_is_sw) begin
                            dm_write = 1'b1;
                            dm_waddr = ms_addr;
                            dm_wdata = ms_wdata;
                        end else begin
                            dm_read  = 1'b1;
                            dm_raddr = ms_addr;
                        end
                    end else if (gnt_ld) begin
                        ld_gnt = 1'b1;
                        if (ld_we) begin
                            dm_write = 1'b1;
                            dm_waddr = ld_addr;
                            dm_wdata = ld_wdata;
                        end else begin
                            dm_read  = 1'b1;
                            dm_raddr = ld_addr;
                        end
                    end
                end
                RD_WAIT: begin
                    dm_read  = 1'b1;
                    dm_raddr = raddr_q;
                end
                RD_DONE: begin
                    ld_rvalid = (own == OWN_LD);
                end
                default: ;
            endcase
            ms_stall = ms_req
                    && !((state == IDLE) && gnt_ms && ms_is_sw)
                    && !((state == RD_DONE) && (own == OWN_MS));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            own      <= OWN_MS;
            cnt      <= '0;
            raddr_q  <= '0;
            ms_rdata <= '0;
            ld_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_gnt) begin
                        state   <= RD_WAIT;
                        cnt     <= CNT_INIT;
                        own     <= gnt_ms ? OWN_MS : OWN_LD;
                        raddr_q <= gnt_ms ? ms_addr : ld_addr;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        if (own == OWN_MS) begin
                            ms_rdata <= dm_rdata;
                        end else begin
                            ld_rdata <= dm_rdata;
                        end
                        state <= RD_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed scoreboard bench for dmem_access_ctrl with a fixed-latency memory model.
module tb_dmem_access_ctrl;

    localparam int MEM_LAT = 2;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ADD = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  ms_opcode;
    logic [31:0] ms_addr;
    logic [31:0] ms_wdata;
    logic [31:0] ms_rdata;
    logic        ms_stall;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_raddr;
    logic [31:0] dm_waddr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] ms_q[$];
    logic [31:0] ld_q[$];
    logic [63:0] wr_q[$];

    logic [31:0] mem[int unsigned];
    int          rd_age = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ms_opcode (ms_opcode),
        .ms_addr   (ms_addr),
        .ms_wdata  (ms_wdata),
        .ms_rdata  (ms_rdata),
        .ms_stall  (ms_stall),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rdata  (ld_rdata),
        .ld_rvalid (ld_rvalid),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_raddr  (dm_raddr),
        .dm_waddr  (dm_waddr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata)
    );

    // Unwritten locations read back as 0xA5A5_0000 | addr.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hA5A5_0000 | a);
    endfunction

    // Read data is only valid MEM_LAT cycles after dm_read first rises.
    always @(posedge clk) begin
        if (dm_write) mem[dm_waddr] = dm_wdata;
        rd_age <= dm_read ? rd_age + 1 : 0;
    end

    always_comb begin
        dm_rdata = 32'hBAD0_BAD0;
        if (dm_read && rd_age == MEM_LAT) dm_rdata = mem_rd(dm_raddr);
    end

    wire [4:0] flags = {ms_stall, dm_read, dm_write, ld_gnt, ld_rvalid};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag, input logic [4:0] exp_f);
        @(negedge clk);
        chk(tag, {27'b0, flags}, {27'b0, exp_f});
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag);
        logic [63:0] e;
        e = wr_q.pop_front();
        chk({tag, "_waddr"}, dm_waddr, e[63:32]);
        chk({tag, "_wdata"}, dm_wdata, e[31:0]);
    endtask

    task automatic ms_load(input string tag, input logic [31:0] a);
        int stall_n = 0;
        int read_n  = 0;
        ms_opcode = LW;
        ms_addr   = a;
        ms_q.push_back(mem_rd(a));
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!ms_stall) break;
            stall_n++;
            if (dm_read) read_n++;
            if (n == 0) chk({tag, "_raddr"}, dm_raddr, a);
            adv();
        end
        chk({tag, "_stall_cycles"}, stall_n, MEM_LAT + 1);
        chk({tag, "_read_cycles"}, read_n, MEM_LAT + 1);
        chk({tag, "_rdata"}, ms_rdata, ms_q.pop_front());
        chk({tag, "_read_done"}, {31'b0, dm_read}, 32'd0);
        adv();
        ms_opcode = ADD;
    endtask

    initial begin
        reset     = 1'b1;
        ms_opcode = LW;
        ms_addr   = 32'h10;
        ms_wdata  = '0;
        ld_req    = 1'b1;
        ld_we     = 1'b0;
        ld_addr   = 32'h20;
        ld_wdata  = '0;

        // Requests present during reset must not be granted.
        adv();
        sample("rst_flags", 5'b00000);
        chk("rst_ms_rdata", ms_rdata, 32'h0);
        chk("rst_ld_rdata", ld_rdata, 32'h0);
        adv();
        sample("rst_flags2", 5'b00000);
        adv();
        reset     = 1'b0;
        ms_opcode = ADD;
        ld_req    = 1'b0;

        // Uncontended store completes in one cycle with no stall.
        ms_opcode = SW;
        ms_addr   = 32'h10;
        ms_wdata  = 32'hDEAD_BEEF;
        wr_q.push_back({32'h10, 32'hDEAD_BEEF});
        sample("sw", 5'b00100);
        chk_write("sw");
        adv();

        ms_load("lw", 32'h10);

        // Conflict right after reset: MEM wins, then the loader wins the next one.
        reset = 1'b1;
        adv();
        reset     = 1'b0;
        ms_opcode = LW;
        ms_addr   = 32'h10;
        ld_req    = 1'b1;
        ld_we     = 1'b0;
        ld_addr   = 32'h20;
        ms_q.push_back(32'hDEAD_BEEF);
        ld_q.push_back(32'hA5A5_0020);
        sample("cf_c0", 5'b11000);
        chk("cf_c0_raddr", dm_raddr, 32'h10);
        adv();
        sample("cf_c1", 5'b11000);
        adv();
        sample("cf_c2", 5'b11000);
        adv();
        sample("cf_c3", 5'b00000);
        chk("cf_ms_rdata", ms_rdata, ms_q.pop_front());
        adv();
        ms_addr = 32'h30;
        ms_q.push_back(32'hA5A5_0030);
        sample("cf_c4_ldgnt", 5'b11010);
        chk("cf_c4_raddr", dm_raddr, 32'h20);
        adv();
        ld_req = 1'b0;
        sample("cf_c5", 5'b11000);
        chk("cf_c5_raddr", dm_raddr, 32'h20);
        adv();
        sample("cf_c6", 5'b11000);
        adv();
        sample("cf_c7_rvalid", 5'b10001);
        chk("cf_ld_rdata", ld_rdata, ld_q.pop_front());
        adv();
        sample("cf_c8", 5'b11000);
        chk("cf_c8_raddr", dm_raddr, 32'h30);
        adv();
        sample("cf_c9", 5'b11000);
        adv();
        sample("cf_c10", 5'b11000);
        adv();
        sample("cf_c11", 5'b00000);
        chk("cf_ms_rdata2", ms_rdata, ms_q.pop_front());
        adv();
        ms_opcode = ADD;

        // Loader write with a non-memory opcode in MEM.
        ld_req   = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 32'h20;
        ld_wdata = 32'h1234;
        wr_q.push_back({32'h20, 32'h1234});
        sample("ldw", 5'b00110);
        chk_write("ldw");
        adv();
        ld_req = 1'b0;
        ld_we  = 1'b0;
        sample("ldw_after", 5'b00000);
        adv();

        ld_req  = 1'b1;
        ld_addr = 32'h20;
        ld_q.push_back(32'h1234);
        sample("ldr_gnt", 5'b01010);
        adv();
        ld_req = 1'b0;
        sample("ldr_w1", 5'b01000);
        adv();
        sample("ldr_w2", 5'b01000);
        adv();
        sample("ldr_rvalid", 5'b00001);
        chk("ldr_rdata", ld_rdata, ld_q.pop_front());
        adv();

        // Reset in the second RD_WAIT cycle abandons the loader read.
        ld_req  = 1'b1;
        ld_addr = 32'h10;
        sample("rm_gnt", 5'b01010);
        adv();
        ld_req = 1'b0;
        sample("rm_w1", 5'b01000);
        adv();
        reset = 1'b1;
        sample("rm_reset", 5'b00000);
        adv();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample("rm_quiet", 5'b00000);
            adv();
        end
        chk("rm_ld_rdata", ld_rdata, 32'h0);

        ms_opcode = SW;
        ms_addr   = 32'h40;
        ms_wdata  = 32'h55AA;
        wr_q.push_back({32'h40, 32'h55AA});
        sample("rm_idle_sw", 5'b00100);
        chk_write("rm_idle_sw");
        adv();
        ms_opcode = ADD;

        chk("sb_empty", ms_q.size() + ld_q.size() + wr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
